// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the compact floating-point path
// (1-bit sign, E_W-bit exponent, F_W-bit significand <-> D_W-bit two's complement).
// Used by both the encoder and the decoder.
//   D_W  - linear data width (two's complement)
//   E_W  - exponent width
//   F_W  - significand width
//   M_W  - magnitude register width (D_W-1, magnitude is never negative)
package fp_pkg;

    localparam int D_W = 12;
    localparam int E_W = 3;
    localparam int F_W = 4;
    localparam int M_W = D_W - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fp_state_e;

    // Turns an unsigned magnitude into a D_W-bit two's complement value.
    // A zero magnitude always yields +0, so negative zero can never appear.
    function automatic logic [D_W-1:0] fp_apply_sign(input logic sign,
                                                     input logic [M_W-1:0] mag);
        logic [D_W-1:0] ext;
        ext = {1'b0, mag};
        if (sign && (mag != '0)) begin
            return ~ext + {{(D_W-1){1'b0}}, 1'b1};
        end
        return ext;
    endfunction

endpackage

// File: rtl/fp_shift_reg.sv
// fp_shift_reg: magnitude/count shift register for the iterative decoder.
// On load the significand is zero-extended into the magnitude and the
// exponent becomes the remaining shift count; each shift doubles the
// magnitude and decrements the count.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - capture f_in / e_in (has priority over shift)
//   shift     - mag <<= 1, cnt -= 1 (caller only shifts while cnt != 0)
//   f_in      - significand to load
//   e_in      - exponent to load as shift count
//   mag       - current magnitude
//   done      - remaining shift count is zero
module fp_shift_reg
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           shift,
    input  logic [F_W-1:0] f_in,
    input  logic [E_W-1:0] e_in,
    output logic [M_W-1:0] mag,
    output logic           done
);

    logic [M_W-1:0] mag_q, mag_d;
    logic [E_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mag_d = mag_q;
        cnt_d = cnt_q;
        if (load) begin
            mag_d = {{(M_W-F_W){1'b0}}, f_in};
            cnt_d = e_in;
        end else if (shift) begin
            // 15 << 7 fits in M_W bits, so the dropped MSB is always zero.
            mag_d = {mag_q[M_W-2:0], 1'b0};
            cnt_d = cnt_q - {{(E_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else begin
            mag_q <= mag_d;
            cnt_q <= cnt_d;
        end
    end

    assign mag  = mag_q;
    assign done = (cnt_q == '0);

endmodule

// File: rtl/fp_decoder.sv
// fp_decoder: iterative decoder from compact float (s, e, f) to a D_W-bit
// two's complement value d = (s ? -1 : 1) * f * 2^e.
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. in_ready is high only in IDLE; out_valid is high only
// in DONE, and d is held stable for as long as out_valid is high. Both are
// decoded from state, so there is no combinational input-to-output path.
// Latency from accept edge to out_valid is e+1 cycles; no overlap.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   in_valid   - encoded word present on s/e/f
//   in_ready   - decoder can accept
//   s, e, f    - sign (1 = negative), exponent, significand
//   out_valid  - d holds a finished result
//   out_ready  - consumer takes d
//   d          - decoded value
module fp_decoder
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           s,
    input  logic [E_W-1:0] e,
    input  logic [F_W-1:0] f,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] d
);

    fp_state_e      state_q, state_d;
    logic           sign_q, sign_d;
    logic [D_W-1:0] d_q, d_d;
    logic           load, shift;
    logic [M_W-1:0] mag;
    logic           done;

    fp_shift_reg u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .f_in  (f),
        .e_in  (e),
        .mag   (mag),
        .done  (done)
    );

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        d_d     = d_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    sign_d  = s;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // f == 0 still shifts e times so latency depends only on e.
                if (!done) begin
                    shift = 1'b1;
                end else begin
                    d_d     = fp_apply_sign(sign_q, mag);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            d_q     <= d_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;

endmodule

// File: tb/tb_fp_decoder.sv
// tb_fp_decoder: directed bench for fp_decoder. The driver pushes the
// hand-computed result and latency for each accepted word into exp_q; a
// monitor pops and compares whenever out_valid rises. Outputs are sampled
// on the falling edge.
module tb_fp_decoder;

    typedef struct {
        logic [11:0] d;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] d;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;
    int   acc_cyc;
    logic ov_prev;

    fp_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .e         (e),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc is only read on the falling edge, so no race with this update.
    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare each new result against the head of the queue.
    initial ov_prev = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: d=0x%0h with nothing expected (t=%0t)", d, $time);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    check("result_d", 32'(d), 32'(x.d));
                    check("latency", 32'(cyc - acc_cyc), 32'(x.lat));
                end
            end
            ov_prev = out_valid;
        end
    end

    // ---------------- driver tasks ----------------
    // Offers one word; the accept edge is the next rising edge.
    task automatic send(input logic si, input logic [2:0] ei, input logic [3:0] fi,
                        input logic [11:0] dexp, input logic push);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", 32'(in_ready), 32'd1);
        s        = si;
        e        = ei;
        f        = fi;
        in_valid = 1'b1;
        acc_cyc  = cyc + 1;
        if (push) exp_q.push_back('{d: dexp, lat: int'(ei) + 1});
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs: they must be ignored after the accept edge.
        s = 1'($urandom_range(0, 1));
        e = 3'($urandom_range(0, 7));
        f = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_within_budget", 32'(out_valid), 32'd1);
        check("in_ready_low_in_done", 32'(in_ready), 32'd0);
    endtask

    // With out_ready high, the block must be back in IDLE one cycle later.
    task automatic finish_txn();
        @(negedge clk);
        check("in_ready_after_transfer", 32'(in_ready), 32'd1);
        check("out_valid_after_transfer", 32'(out_valid), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks    = 0;
        errors    = 0;
        acc_cyc   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = 1'b0;
        e         = '0;
        f         = '0;
        repeat (3) @(negedge clk);
        // in_valid high during reset must be ignored
        in_valid = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_d", 32'(d), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        out_ready = 1'b1;

        // zero
        send(1'b0, 3'd0, 4'd0, 12'h000, 1'b1);
        wait_done(20);
        finish_txn();

        // positive: 11 << 2 = 44
        send(1'b0, 3'd2, 4'b1011, 12'h02C, 1'b1);
        wait_done(20);
        finish_txn();

        // negative extreme: -(15 << 7) = -1920
        send(1'b1, 3'd7, 4'hF, 12'h880, 1'b1);
        wait_done(20);
        finish_txn();

        // no negative zero
        send(1'b1, 3'd3, 4'd0, 12'h000, 1'b1);
        wait_done(20);
        finish_txn();

        // backpressure: 5 << 1 = 10, held while out_ready low
        out_ready = 1'b0;
        send(1'b0, 3'd1, 4'd5, 12'h00A, 1'b1);
        wait_done(20);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                s        = 1'b1;
                e        = 3'd0;
                f        = 4'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_d_stable", 32'(d), 32'h00A);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_txn();
        repeat (4) @(negedge clk);
        check("bp_pulsed_word_ignored", 32'(out_valid), 32'd0);

        // reset in the middle of a shift
        send(1'b0, 3'd6, 4'd9, 12'h000, 1'b0);
        @(negedge clk);
        check("mid_shift_busy", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_d", 32'(d), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_discarded_result", 32'(out_valid), 32'd0);

        // after reset: -1
        send(1'b1, 3'd0, 4'd1, 12'hFFF, 1'b1);
        wait_done(20);
        finish_txn();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
